// File: rtl/neo_strand_controller_param.sv
// WS2812-class strand driver: per-pixel RGB buffer, brightness scaling,
// configurable bit timing and colour order, latch gap with frame-done pulse.
module neo_strand_controller_param #(
  parameter int NUM_PIXELS  = 5,
  parameter int IDX_W       = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1,
  parameter int T0H_CYC     = 18,
  parameter int T1H_CYC     = 35,
  parameter int BIT_CYC     = 63,
  parameter int LATCH_CYC   = 2500,
  parameter int COLOR_ORDER = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] pixel_index,
  input  logic [1:0]       color_index,
  input  logic [7:0]       color_level,
  input  logic             load_color,
  input  logic             send_it,
  input  logic [7:0]       brightness,
  output logic             neo_data,
  output logic             ready_to_load,
  output logic             ready_to_send,
  output logic             frame_done
);

  localparam int CYC_W = $clog2(BIT_CYC + 1);
  localparam int LAT_W = $clog2(LATCH_CYC + 1);
  localparam logic [CYC_W-1:0] BIT_LAST = CYC_W'(BIT_CYC - 1);
  localparam logic [CYC_W-1:0] T0H      = CYC_W'(T0H_CYC);
  localparam logic [CYC_W-1:0] T1H      = CYC_W'(T1H_CYC);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYC - 1);
  localparam logic [LAT_W-1:0] LAT_DONE = LAT_W'(LATCH_CYC);
  localparam logic [IDX_W-1:0] PIX_LAST = IDX_W'(NUM_PIXELS - 1);
  localparam logic [IDX_W:0]   NPIX     = (IDX_W + 1)'(NUM_PIXELS);

  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

  state_t           state;
  logic [7:0]       mem [NUM_PIXELS][3];
  logic [IDX_W-1:0] pix_cnt;
  logic [1:0]       byte_cnt;
  logic [2:0]       bit_cnt;
  logic [CYC_W-1:0] cyc_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic [7:0]       bright;

  logic [7:0]       tx_byte;
  logic             tx_bit;
  logic [CYC_W-1:0] high_cyc;
  logic [CYC_W-1:0] cyc_inc;
  logic             load_ok;
  logic             last_bit;

  // Wire byte slot -> buffer colour index (0 = red, 1 = green, 2 = blue).
  function automatic logic [1:0] wire_color(input logic [1:0] slot);
    if (COLOR_ORDER == 0) begin
      case (slot)
        2'd0:    return 2'd1;
        2'd1:    return 2'd0;
        default: return 2'd2;
      endcase
    end
    return slot;
  endfunction

  function automatic logic [7:0] scale(input logic [7:0] level, input logic [7:0] br);
    logic [15:0] prod;
    prod = {8'd0, level} * ({8'd0, br} + 16'd1);
    return prod[15:8];
  endfunction

  always_comb begin
    tx_byte  = scale(mem[pix_cnt][wire_color(byte_cnt)], bright);
    tx_bit   = tx_byte[bit_cnt];
    high_cyc = tx_bit ? T1H : T0H;
    cyc_inc  = cyc_cnt + CYC_W'(1);
    load_ok  = load_color && ready_to_load && ({1'b0, pixel_index} < NPIX) &&
               (color_index != 2'd3);
    last_bit = (pix_cnt == PIX_LAST) && (byte_cnt == 2'd2) && (bit_cnt == 3'd0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NUM_PIXELS; p++)
        for (int c = 0; c < 3; c++)
          mem[p][c] <= 8'd0;
    end else if (load_ok) begin
      mem[pixel_index][color_index] <= color_level;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      neo_data      <= 1'b0;
      ready_to_load <= 1'b1;
      ready_to_send <= 1'b1;
      frame_done    <= 1'b0;
      pix_cnt       <= '0;
      byte_cnt      <= 2'd0;
      bit_cnt       <= 3'd7;
      cyc_cnt       <= '0;
      lat_cnt       <= '0;
      bright        <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          frame_done <= 1'b0;
          if (send_it) begin
            state         <= SEND;
            pix_cnt       <= '0;
            byte_cnt      <= 2'd0;
            bit_cnt       <= 3'd7;
            cyc_cnt       <= '0;
            bright        <= brightness;
            neo_data      <= 1'b1;
            ready_to_load <= 1'b0;
            ready_to_send <= 1'b0;
          end
        end
        SEND: begin
          // Bit windows run back to back; each starts with the line high.
          if (cyc_cnt == BIT_LAST) begin
            cyc_cnt <= '0;
            if (last_bit) begin
              state         <= LATCH;
              neo_data      <= 1'b0;
              lat_cnt       <= '0;
              ready_to_load <= 1'b1;
            end else begin
              neo_data <= 1'b1;
              if (bit_cnt == 3'd0) begin
                bit_cnt <= 3'd7;
                if (byte_cnt == 2'd2) begin
                  byte_cnt <= 2'd0;
                  pix_cnt  <= pix_cnt + IDX_W'(1);
                end else begin
                  byte_cnt <= byte_cnt + 2'd1;
                end
              end else begin
                bit_cnt <= bit_cnt - 3'd1;
              end
            end
          end else begin
            cyc_cnt  <= cyc_inc;
            neo_data <= (cyc_inc < high_cyc);
          end
        end
        LATCH: begin
          // LATCH_CYC low cycles, then one more cycle carrying frame_done.
          if (lat_cnt == LAT_DONE) begin
            state         <= IDLE;
            frame_done    <= 1'b0;
            ready_to_send <= 1'b1;
          end else begin
            lat_cnt    <= lat_cnt + LAT_W'(1);
            frame_done <= (lat_cnt == LAT_LAST);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neo_strand_controller_param.sv
// Directed bench for neo_strand_controller_param: decodes every transmitted
// bit by pulse width and compares whole frames against hand-computed vectors.
module tb_neo_strand_controller_param;

  localparam int NP   = 5;
  localparam int BITS = NP * 24;
  localparam int BCYC = 63;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] pixel_index = 3'd0;
  logic [1:0] color_index = 2'd0;
  logic [7:0] color_level = 8'd0;
  logic       load_color = 1'b0;
  logic       send_it = 1'b0;
  logic [7:0] brightness = 8'd0;
  logic       neo_data;
  logic       ready_to_load;
  logic       ready_to_send;
  logic       frame_done;

  int nchecks = 0;
  int nerrors = 0;

  always #5 clock = ~clock;

  neo_strand_controller_param #(
    .NUM_PIXELS(NP), .IDX_W(3), .T0H_CYC(18), .T1H_CYC(35),
    .BIT_CYC(BCYC), .LATCH_CYC(2500), .COLOR_ORDER(0)
  ) dut (
    .clock(clock), .reset(reset), .pixel_index(pixel_index),
    .color_index(color_index), .color_level(color_level),
    .load_color(load_color), .send_it(send_it), .brightness(brightness),
    .neo_data(neo_data), .ready_to_load(ready_to_load),
    .ready_to_send(ready_to_send), .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [119:0] got, input logic [119:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [2:0] pix, input logic [1:0] col, input logic [7:0] lvl);
    pixel_index = pix;
    color_index = col;
    color_level = lvl;
    load_color  = 1'b1;
    tick();
    load_color  = 1'b0;
  endtask

  // mode 1: poke send_it/load during SEND; mode 2: poke them during LATCH.
  task automatic capture(input int mode, output logic [119:0] v, output int bad, output int lat);
    int  hi;
    logic prev;
    v   = '0;
    bad = 0;
    for (int k = 0; k < BITS; k++) begin
      hi   = 0;
      prev = 1'b0;
      for (int c = 0; c < BCYC; c++) begin
        if (mode == 1 && k == 10 && c == 5) begin
          pixel_index = 3'd0; color_index = 2'd1; color_level = 8'hFF;
          load_color = 1'b1; send_it = 1'b1;
        end else if (mode == 1 && k == 10 && c == 6) begin
          load_color = 1'b0; send_it = 1'b0;
        end
        if (c == 0 && neo_data !== 1'b1) bad++;
        if (c > 0 && neo_data === 1'b1 && prev !== 1'b1) bad++;
        if (neo_data === 1'b1) hi++;
        prev = neo_data;
        tick();
      end
      if (hi == 35) v[BITS-1-k] = 1'b1;
      else if (hi != 18) bad++;
    end
    lat = 0;
    while (frame_done !== 1'b1 && lat < 3000) begin
      if (neo_data !== 1'b0) bad++;
      if (mode == 2 && lat == 100) begin
        pixel_index = 3'd4; color_index = 2'd2; color_level = 8'h3C;
        load_color = 1'b1; send_it = 1'b1;
      end else if (mode == 2 && lat == 101) begin
        load_color = 1'b0; send_it = 1'b0;
      end
      tick();
      lat++;
    end
  endtask

  task automatic frame(input string tag, input logic [7:0] br, input int mode,
                       input logic [119:0] exp);
    logic [119:0] v;
    int bad;
    int lat;
    send_it    = 1'b1;
    brightness = br;
    tick();
    send_it    = 1'b0;
    load_color = 1'b0;
    check({tag, "_rise"}, 120'(neo_data), 120'd1);
    check({tag, "_rdy_send"}, 120'({ready_to_load, ready_to_send}), 120'd0);
    capture(mode, v, bad, lat);
    check({tag, "_bits"}, v, exp);
    check({tag, "_pulses"}, 120'(bad), 120'd0);
    check({tag, "_latch_len"}, 120'(lat), 120'd2500);
    check({tag, "_rdy_done"}, 120'({ready_to_load, ready_to_send}), 120'b10);
    tick();
    check({tag, "_after"}, 120'({frame_done, ready_to_send, neo_data}), 120'b010);
  endtask

  initial begin
    int fdc;
    repeat (3) tick();
    check("reset_outs", 120'({neo_data, ready_to_load, ready_to_send, frame_done}), 120'b0110);
    reset = 1'b0;
    tick();

    // Pixel 0: R=FF G=00 B=81, wire order G,R,B.
    load(3'd0, 2'd0, 8'hFF);
    load(3'd0, 2'd1, 8'h00);
    load(3'd0, 2'd2, 8'h81);
    frame("single", 8'd255, 0, {8'h00, 8'hFF, 8'h81, 96'h0});

    // Out-of-range pixel and reserved colour must not land anywhere.
    load(3'd5, 2'd0, 8'hAA);
    load(3'd1, 2'd3, 8'h55);

    // Same-cycle load + send; brightness 128: FF->80, 81->41, C8->64.
    pixel_index = 3'd2; color_index = 2'd1; color_level = 8'd200; load_color = 1'b1;
    frame("bright128", 8'd128, 1,
          {8'h00, 8'h80, 8'h41, 24'h0, 8'h64, 16'h0, 48'h0});

    frame("bright0", 8'd0, 2, 120'h0);

    frame("full", 8'd255, 0,
          {8'h00, 8'hFF, 8'h81, 24'h0, 8'hC8, 16'h0, 24'h0, 16'h0, 8'h3C});

    // Abort mid-frame during bit 40 while the line is high.
    send_it = 1'b1; brightness = 8'd255;
    tick();
    send_it = 1'b0;
    repeat (40 * BCYC + 3) tick();
    check("mid_pre", 120'(neo_data), 120'd1);
    #2 reset = 1'b1;
    #1 check("mid_reset_outs",
             120'({neo_data, ready_to_load, ready_to_send, frame_done}), 120'b0110);
    @(posedge clock);
    #1 reset = 1'b0;
    fdc = 0;
    for (int i = 0; i < 50; i++) begin
      if (frame_done === 1'b1) fdc++;
      tick();
    end
    check("mid_no_done", 120'(fdc), 120'd0);
    frame("post_rst", 8'd255, 0, 120'h0);

    $display("CHECKS %0d ERRORS %0d", nchecks, nerrors);
    $finish;
  end

endmodule
